toccata_capture_ctrl: RTL and testbench
=======================================

Name: toccata_capture_ctrl

Overview:
- Sequences the Toccata capture FIFO on behalf of the Zorro register interface.
- Enables and disables capture, raises the half-full interrupt, and counts the host's drain burst.
- Turns host data-register reads into single-cycle FIFO read strobes, and tracks sticky overrun, underrun and stall errors.
- Sits between the register decoder and toccata_capture.

Parameters:
- FIFO_SIZE, 1024: capture FIFO depth in bytes. Must match the capture block.
- BURST_LEN, FIFO_SIZE/2: host reads that complete one interrupt-driven drain.
- STALL_CYCLES, 65536: clk cycles allowed from arm to the first endata before a stall is declared.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  control-register write strobe
- cfg_cen  in  1  capture enable value, sampled on cfg_wr
- cfg_ien  in  1  interrupt enable value, sampled on cfg_wr
- cfg_autostop  in  1  stop capture on overrun, sampled on cfg_wr
- status_rd  in  1  status-register read strobe; clears sticky flags
- status  out  8  {state[2:0], irq, overrun, underrun, stall, cap_empty}
- data_rd  in  1  host data-register read strobe
- data_rdata  out  8  byte returned to the host
- data_ack  out  1  one-cycle pulse; data_rdata is valid while it is high
- irq  out  1  interrupt request, active high
- cap_cen  out  1  to toccata_capture cen
- cap_rd  out  1  to toccata_capture rd
- cap_data  in  8  from toccata_capture data_out
- cap_empty, cap_half_full, cap_full, cap_endata  in  1 each  capture status and strobe

Behaviour:
- Reset: state=IDLE; all outputs 0; all counters, config and sticky flags 0.
- FSM states are IDLE, ARM, RUN, DRAIN, OVERRUN. cap_cen=1 in ARM, RUN and DRAIN.
- IDLE:
  - cfg_wr with cfg_cen=1 -> ARM. The stall counter loads 0.
- ARM:
  - cap_endata -> RUN.
  - Stall counter reaching STALL_CYCLES-1 -> IDLE and stall=1.
- RUN:
  - cap_half_full=1 with ien=1 -> DRAIN. irq is set to 1 registered on that transition; burst_cnt loads 0.
- DRAIN:
  - Each accepted data read increments burst_cnt.
  - burst_cnt reaching BURST_LEN -> RUN with irq=0.
  - cap_half_full=0 -> RUN with irq=0, regardless of burst_cnt.
- Overrun (RUN or DRAIN):
  - cap_endata while cap_full=1 sets overrun=1.
  - If autostop=1 -> OVERRUN, where cap_cen=0 and irq=0.
- Any state: cfg_wr with cfg_cen=0 -> IDLE.
  - burst_cnt, stall counter and irq are cleared.
  - overrun is kept until status_rd.
- Data read pipeline:
  - A data_rd at cycle N is accepted when no read is in flight.
  - cap_rd=1 at N+1 only if cap_empty=0 at N.
  - cap_data is sampled at the end of N+2. data_rdata is updated and data_ack=1 at N+3.
  - If cap_empty=1 at N: no cap_rd, data_rdata=8'h00, data_ack=1 at N+3, underrun=1.
  - data_rd while a read is in flight is ignored: no ack, no flags.
  - Reads are honoured in every state, including IDLE and OVERRUN.
- Sticky flags: status_rd clears overrun, underrun and stall. If a flag-set event and status_rd fall on the same edge, the set wins.
- Simultaneous cfg_wr and data_rd: both take effect. An in-flight read completes even if capture is disabled.
- burst_cnt is $clog2(BURST_LEN)+1 bits wide and saturates at BURST_LEN.
- Stall counter saturates; it never wraps.
- rst_n asserted mid-read: the read is aborted and no ack is issued.

Decomposition:
- toccata_pkg: ctrl_state_e enum (3 bits, IDLE=0, ARM=1, RUN=2, DRAIN=3, OVERRUN=4) and STATUS_* bit-index constants.
- Sub-module toccata_stall_timer: saturating down-counter with load, enable and expired signals.

Test Plan:
- Reset, then cfg_wr cen=1 ien=1; one cap_endata -> state=RUN, cap_cen=1, status[7:5]=3'd2.
- In RUN raise cap_half_full -> irq=1 next cycle. Issue 512 spaced data_rd with cap_data=8'h80 -> 512 acks, data_rdata=8'h80, irq=0 after the 512th accepted read, state=RUN.
- data_rd with cap_empty=1 -> no cap_rd, data_ack at N+3 with data_rdata=8'h00, underrun=1. status_rd -> underrun=0.
- autostop=1; cap_full=1 with cap_endata -> overrun=1, state=OVERRUN, cap_cen=0. cfg_wr cen=0 -> IDLE, overrun stays 1 until status_rd.
- Arm with STALL_CYCLES=16 and no endata -> IDLE after 16 cycles with stall=1.
- Second data_rd at N+1 while a read is in flight -> exactly one cap_rd pulse and one data_ack. rst_n low at N+1 -> no ack.

Source files
------------

// File: rtl/toccata_pkg.sv
// Shared types for the Toccata capture controller: FSM state encoding and
// bit positions inside the host-visible status byte.
package toccata_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        OVERRUN = 3'd4
    } ctrl_state_e;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_STALL     = 1;
    localparam int STATUS_UNDERRUN  = 2;
    localparam int STATUS_OVERRUN   = 3;
    localparam int STATUS_IRQ       = 4;
    localparam int STATUS_STATE_LSB = 5;

endpackage

// File: rtl/toccata_stall_timer.sv
// Saturating down-counter guarding the wait for the first capture strobe.
// expired is high whenever the count sits at zero.
module toccata_stall_timer #(
    parameter int unsigned CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/toccata_capture_ctrl.sv
// Capture-FIFO sequencer between the Zorro register decoder and toccata_capture:
// enable/arm, half-full drain interrupt, host read strobes and sticky errors.
//
// state   | meaning
// IDLE    | capture off, waiting for an enabling control write
// ARM     | capture on, waiting for the first endata (stall timer running)
// RUN     | capturing, no drain pending
// DRAIN   | half-full interrupt raised, counting the host drain burst
// OVERRUN | capture stopped after an overrun with autostop set
module toccata_capture_ctrl
    import toccata_pkg::*;
#(
    parameter int unsigned FIFO_SIZE    = 1024,
    parameter int unsigned BURST_LEN    = FIFO_SIZE / 2,
    parameter int unsigned STALL_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_wr,
    input  logic       cfg_cen,
    input  logic       cfg_ien,
    input  logic       cfg_autostop,
    input  logic       status_rd,
    output logic [7:0] status,
    input  logic       data_rd,
    output logic [7:0] data_rdata,
    output logic       data_ack,
    output logic       irq,
    output logic       cap_cen,
    output logic       cap_rd,
    input  logic [7:0] cap_data,
    input  logic       cap_empty,
    input  logic       cap_half_full,
    input  logic       cap_full,
    input  logic       cap_endata
);

    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    ctrl_state_e state, state_nxt;

    logic          ien_q, autostop_q;
    logic          irq_q;
    logic          overrun_q, underrun_q, stall_q;
    logic          cap_empty_q;
    logic [BW-1:0] burst_cnt;
    logic          rd_p1, rd_p1_ok, rd_p2, rd_p2_ok;
    logic          ack_q;
    logic [7:0]    rdata_q;
    logic          stall_expired;
    logic          stall_evt;

    logic cfg_start, cfg_stop, rd_accept, ovf_evt, burst_done, drain_enter;

    assign cfg_start   = cfg_wr & cfg_cen;
    assign cfg_stop    = cfg_wr & ~cfg_cen;
    assign rd_accept   = data_rd & ~(rd_p1 | rd_p2);
    assign ovf_evt     = cap_endata & cap_full & ((state == RUN) || (state == DRAIN));
    assign burst_done  = (burst_cnt == BURST_MAX);
    assign drain_enter = (state == RUN) && (state_nxt == DRAIN);

    always_comb begin
        state_nxt = state;
        stall_evt = 1'b0;
        if (cfg_stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cfg_start) state_nxt = ARM;
                ARM: begin
                    if (cap_endata) begin
                        state_nxt = RUN;
                    end else if (stall_expired) begin
                        state_nxt = IDLE;
                        stall_evt = 1'b1;
                    end
                end
                RUN: begin
                    if (ovf_evt && autostop_q)        state_nxt = OVERRUN;
                    else if (cap_half_full && ien_q)  state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (ovf_evt && autostop_q)             state_nxt = OVERRUN;
                    else if (burst_done || !cap_half_full) state_nxt = RUN;
                end
                OVERRUN: state_nxt = OVERRUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            irq_q       <= 1'b0;
            ien_q       <= 1'b0;
            autostop_q  <= 1'b0;
            burst_cnt   <= '0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            stall_q     <= 1'b0;
            cap_empty_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            irq_q       <= (state_nxt == DRAIN);
            cap_empty_q <= cap_empty;
            if (cfg_wr) begin
                ien_q      <= cfg_ien;
                autostop_q <= cfg_autostop;
            end
            if (cfg_stop || drain_enter) begin
                burst_cnt <= '0;
            end else if ((state == DRAIN) && rd_accept && !burst_done) begin
                burst_cnt <= burst_cnt + BURST_ONE;
            end
            // A set event on the same edge as status_rd must survive the clear.
            if (ovf_evt)        overrun_q <= 1'b1;
            else if (status_rd) overrun_q <= 1'b0;
            if (rd_p2 && !rd_p2_ok) underrun_q <= 1'b1;
            else if (status_rd)     underrun_q <= 1'b0;
            if (stall_evt)      stall_q <= 1'b1;
            else if (status_rd) stall_q <= 1'b0;
        end
    end

    // Host read pipeline: accept, FIFO strobe, sample, ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1    <= 1'b0;
            rd_p1_ok <= 1'b0;
            rd_p2    <= 1'b0;
            rd_p2_ok <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            rd_p1    <= rd_accept;
            rd_p1_ok <= rd_accept & ~cap_empty;
            rd_p2    <= rd_p1;
            rd_p2_ok <= rd_p1_ok;
            ack_q    <= rd_p2;
            if (rd_p2) rdata_q <= rd_p2_ok ? cap_data : 8'h00;
        end
    end

    toccata_stall_timer #(
        .CYCLES (STALL_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    ((state == IDLE) && (state_nxt == ARM)),
        .clr     (cfg_stop),
        .en      (state == ARM),
        .expired (stall_expired)
    );

    assign cap_cen    = (state == ARM) || (state == RUN) || (state == DRAIN);
    assign cap_rd     = rd_p1_ok;
    assign irq        = irq_q;
    assign data_ack   = ack_q;
    assign data_rdata = rdata_q;
    assign status     = {state, irq_q, overrun_q, underrun_q, stall_q, cap_empty_q};

endmodule

// File: tb/tb_toccata_capture_ctrl.sv
// Directed bench for toccata_capture_ctrl with a shortened stall window.
module tb_toccata_capture_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_wr, cfg_cen, cfg_ien, cfg_autostop;
    logic       status_rd;
    logic [7:0] status;
    logic       data_rd;
    logic [7:0] data_rdata;
    logic       data_ack;
    logic       irq;
    logic       cap_cen;
    logic       cap_rd;
    logic [7:0] cap_data;
    logic       cap_empty, cap_half_full, cap_full, cap_endata;

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    int caprd_cnt = 0;
    int ack0, rd0;

    toccata_capture_ctrl #(
        .FIFO_SIZE    (1024),
        .STALL_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wr        (cfg_wr),
        .cfg_cen       (cfg_cen),
        .cfg_ien       (cfg_ien),
        .cfg_autostop  (cfg_autostop),
        .status_rd     (status_rd),
        .status        (status),
        .data_rd       (data_rd),
        .data_rdata    (data_rdata),
        .data_ack      (data_ack),
        .irq           (irq),
        .cap_cen       (cap_cen),
        .cap_rd        (cap_rd),
        .cap_data      (cap_data),
        .cap_empty     (cap_empty),
        .cap_half_full (cap_half_full),
        .cap_full      (cap_full),
        .cap_endata    (cap_endata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_ack) ack_cnt++;
        if (cap_rd)   caprd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // data_rd in cycle N; strobe at N+1, ack and data at N+3.
    task automatic do_read(input logic [7:0] d, input logic empty, input bit last);
        cap_data  = d;
        cap_empty = empty;
        data_rd   = 1'b1;
        tick();
        data_rd = 1'b0;
        check("cap_rd_n1", cap_rd, !empty);
        check("ack_n1", data_ack, 1'b0);
        tick();
        if (last) begin
            check("irq_burst_end", irq, 1'b0);
            check("state_burst_end", status[7:5], 3'd2);
            cap_half_full = 1'b0;
        end
        check("cap_rd_n2", cap_rd, 1'b0);
        tick();
        check("ack_n3", data_ack, 1'b1);
        check("rdata_n3", data_rdata, empty ? 8'h00 : d);
        tick();
        check("ack_n4", data_ack, 1'b0);
    endtask

    task automatic do_cfg(input logic cen, input logic ien, input logic autostop);
        cfg_wr = 1'b1; cfg_cen = cen; cfg_ien = ien; cfg_autostop = autostop;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_status_rd();
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_wr = 0; cfg_cen = 0; cfg_ien = 0; cfg_autostop = 0;
        status_rd = 0; data_rd = 0; cap_data = 8'h00;
        cap_empty = 0; cap_half_full = 0; cap_full = 0; cap_endata = 0;
        repeat (3) tick();
        check("rst_status", status, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_cap_cen", cap_cen, 1'b0);
        check("rst_cap_rd", cap_rd, 1'b0);
        check("rst_ack", data_ack, 1'b0);
        check("rst_rdata", data_rdata, 8'h00);
        rst_n = 1'b1;
        tick();

        // Arm, then first endata moves to RUN
        do_cfg(1'b1, 1'b1, 1'b0);
        check("arm_state", status[7:5], 3'd1);
        check("arm_cap_cen", cap_cen, 1'b1);
        cap_endata = 1'b1;
        tick();
        cap_endata = 1'b0;
        check("run_state", status[7:5], 3'd2);
        check("run_cap_cen", cap_cen, 1'b1);
        check("run_irq", irq, 1'b0);

        // Half-full raises irq; 512-read drain returns to RUN
        cap_half_full = 1'b1;
        tick();
        check("drain_irq", irq, 1'b1);
        check("drain_state", status[7:5], 3'd3);
        ack0 = ack_cnt;
        for (int i = 0; i < 512; i++) begin
            do_read(8'h80, 1'b0, i == 511);
            if (i == 510) check("irq_held_511", irq, 1'b1);
        end
        check("burst_acks", ack_cnt - ack0, 512);
        check("post_burst_state", status[7:5], 3'd2);
        check("post_burst_irq", irq, 1'b0);

        // Underrun on empty FIFO
        do_read(8'hAA, 1'b1, 1'b0);
        check("underrun_set", status[2], 1'b1);
        do_status_rd();
        check("underrun_clr", status[2], 1'b0);

        // Overrun with autostop; status_rd on the same edge must lose
        do_cfg(1'b1, 1'b1, 1'b1);
        check("cfg_in_run_state", status[7:5], 3'd2);
        cap_full = 1'b1; cap_endata = 1'b1; status_rd = 1'b1;
        tick();
        cap_full = 1'b0; cap_endata = 1'b0; status_rd = 1'b0;
        check("ovr_flag", status[3], 1'b1);
        check("ovr_state", status[7:5], 3'd4);
        check("ovr_cap_cen", cap_cen, 1'b0);
        check("ovr_irq", irq, 1'b0);
        do_cfg(1'b0, 1'b0, 1'b0);
        check("stop_state", status[7:5], 3'd0);
        check("stop_ovr_kept", status[3], 1'b1);
        tick();
        check("ovr_still_kept", status[3], 1'b1);
        do_status_rd();
        check("ovr_clr", status[3], 1'b0);

        // Stall: 16 cycles in ARM without endata
        do_cfg(1'b1, 1'b0, 1'b0);
        check("stall_arm", status[7:5], 3'd1);
        repeat (15) tick();
        check("stall_arm_15", status[7:5], 3'd1);
        check("stall_not_yet", status[1], 1'b0);
        tick();
        check("stall_idle", status[7:5], 3'd0);
        check("stall_flag", status[1], 1'b1);
        check("stall_cap_cen", cap_cen, 1'b0);
        do_status_rd();
        check("stall_clr", status[1], 1'b0);

        // Second data_rd while a read is in flight is ignored
        ack0 = ack_cnt; rd0 = caprd_cnt;
        cap_empty = 1'b0; cap_data = 8'h5A;
        data_rd = 1'b1;
        tick();
        tick();
        data_rd = 1'b0;
        tick();
        check("inflight_ack", data_ack, 1'b1);
        check("inflight_rdata", data_rdata, 8'h5A);
        repeat (3) tick();
        check("inflight_ack_count", ack_cnt - ack0, 1);
        check("inflight_caprd_count", caprd_cnt - rd0, 1);
        check("inflight_underrun", status[2], 1'b0);

        // Reset during a read aborts it
        ack0 = ack_cnt;
        data_rd = 1'b1;
        tick();
        data_rd = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst_mid_ack_count", ack_cnt - ack0, 0);
        check("rst_mid_ack", data_ack, 1'b0);
        check("rst_mid_status", status, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
